// File: rtl/dataslot_request_handler.sv
// Data-slot request handler: scans the BRAM data table for a requested slot ID,
// returns its size and, on writes, replaces that size with the core's save size.
module dataslot_request_handler #(
  parameter int unsigned NUM_SLOTS = 32,
  parameter logic [31:0] MAX_SIZE  = 32'h0080_0000
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        dataslot_requestread,
  input  logic [15:0] dataslot_requestread_id,
  output logic        dataslot_requestread_ack,
  output logic        dataslot_requestread_ok,

  input  logic        dataslot_requestwrite,
  input  logic [15:0] dataslot_requestwrite_id,
  output logic        dataslot_requestwrite_ack,
  output logic        dataslot_requestwrite_ok,

  input  logic [31:0] wr_size,

  output logic [9:0]  datatable_addr,
  output logic        datatable_wren,
  output logic [31:0] datatable_data,
  input  logic [31:0] datatable_q,

  output logic [15:0] slot_id,
  output logic [31:0] slot_size,
  output logic        slot_done,
  output logic        busy
);

  localparam int unsigned     IDX_W    = 9;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_CMP,
    S_RD_SZ,
    S_GET_SZ,
    S_WR_SZ,
    S_ACK
  } state_t;

  state_t           state;
  logic             is_wr;
  logic [15:0]      req_id;
  logic [IDX_W-1:0] idx;
  logic             served_rd;
  logic             served_wr;

  logic             rd_pend;
  logic             wr_pend;
  logic             id_match;
  logic             fin;
  logic             fin_ok;

  // fin marks the edge that enters ACK, so ack/ok/slot_id are visible during ACK
  always_comb begin
    rd_pend  = dataslot_requestread  & ~served_rd;
    wr_pend  = dataslot_requestwrite & ~served_wr;
    id_match = (datatable_q[15:0] == req_id);
    fin      = 1'b0;
    fin_ok   = 1'b0;
    case (state)
      S_CMP: begin
        fin = !id_match && (idx == LAST_IDX);
      end
      S_GET_SZ: begin
        fin    = !is_wr;
        fin_ok = (datatable_q <= MAX_SIZE);
      end
      S_WR_SZ: begin
        fin    = 1'b1;
        fin_ok = 1'b1;
      end
      default: begin
        fin    = 1'b0;
        fin_ok = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                     <= S_IDLE;
      is_wr                     <= 1'b0;
      req_id                    <= '0;
      idx                       <= '0;
      served_rd                 <= 1'b0;
      served_wr                 <= 1'b0;
      dataslot_requestread_ack  <= 1'b0;
      dataslot_requestread_ok   <= 1'b0;
      dataslot_requestwrite_ack <= 1'b0;
      dataslot_requestwrite_ok  <= 1'b0;
      datatable_addr            <= '0;
      datatable_wren            <= 1'b0;
      datatable_data            <= '0;
      slot_id                   <= '0;
      slot_size                 <= '0;
      slot_done                 <= 1'b0;
      busy                      <= 1'b0;
    end else begin
      dataslot_requestread_ack  <= 1'b0;
      dataslot_requestwrite_ack <= 1'b0;
      slot_done                 <= 1'b0;
      if (!dataslot_requestread)  served_rd <= 1'b0;
      if (!dataslot_requestwrite) served_wr <= 1'b0;

      case (state)
        S_IDLE: begin
          if (rd_pend) begin
            is_wr                   <= 1'b0;
            req_id                  <= dataslot_requestread_id;
            dataslot_requestread_ok <= 1'b0;
            idx                     <= '0;
            datatable_addr          <= '0;
            busy                    <= 1'b1;
            state                   <= S_RD_ID;
          end else if (wr_pend) begin
            is_wr                    <= 1'b1;
            req_id                   <= dataslot_requestwrite_id;
            dataslot_requestwrite_ok <= 1'b0;
            idx                      <= '0;
            datatable_addr           <= '0;
            busy                     <= 1'b1;
            state                    <= S_RD_ID;
          end
        end
        S_RD_ID: state <= S_CMP;
        S_CMP: begin
          if (id_match) begin
            datatable_addr <= {idx, 1'b1};
            state          <= S_RD_SZ;
          end else if (idx == LAST_IDX) begin
            slot_size <= '0;
            state     <= S_ACK;
          end else begin
            idx            <= idx + IDX_ONE;
            datatable_addr <= {idx + IDX_ONE, 1'b0};
            state          <= S_RD_ID;
          end
        end
        S_RD_SZ: state <= S_GET_SZ;
        S_GET_SZ: begin
          slot_size <= datatable_q;
          if (is_wr) begin
            datatable_wren <= 1'b1;
            datatable_data <= wr_size;
            state          <= S_WR_SZ;
          end else begin
            state <= S_ACK;
          end
        end
        S_WR_SZ: begin
          datatable_wren <= 1'b0;
          state          <= S_ACK;
        end
        S_ACK: begin
          if (is_wr) begin
            if (dataslot_requestwrite) served_wr <= 1'b1;
          end else begin
            if (dataslot_requestread) served_rd <= 1'b1;
          end
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (fin) begin
        slot_done <= 1'b1;
        slot_id   <= req_id;
        if (is_wr) begin
          dataslot_requestwrite_ack <= 1'b1;
          dataslot_requestwrite_ok  <= fin_ok;
        end else begin
          dataslot_requestread_ack <= 1'b1;
          dataslot_requestread_ok  <= fin_ok;
        end
      end
    end
  end

endmodule
